// File: rtl/cnt_seq_pkg.sv
// -----------------------------------------------------------------------------
// cnt_seq_pkg
// Shared types for the counter sequencing controller.
//   state_t : controller state encoding (S_IDLE, S_LOAD, S_RUN)
// -----------------------------------------------------------------------------
package cnt_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/cnt_seq_ctrl.sv
// -----------------------------------------------------------------------------
// cnt_seq_ctrl
// Sequencing controller for a loadable up-counter. It loads the counter with a
// latched base value and lets it count up to a latched limit. It then either
// reloads for another interval or stops with the counter holding at the limit.
//
// Ports
//   Clk     in   rising-edge clock
//   reset   in   synchronous, active-high reset
//   start   in   begin a sequence (only looked at in IDLE)
//   stop    in   abort, honoured in every state, highest priority
//   base    in   [n-1:0] interval start value, latched on accepted start
//   limit   in   [n-1:0] interval end value, latched on accepted start
//   reps    in   [m-1:0] interval count, 0 = run until stop
//   cnt_q   in   [n-1:0] counter output
//   cnt_en  out  counter enable      (combinational)
//   cnt_ld  out  counter load        (combinational)
//   cnt_d   out  [n-1:0] counter load data = latched base
//   busy    out  high while in LOAD or RUN (registered)
//   tick    out  interval-end pulse  (combinational)
//   done    out  sequence-complete pulse (registered)
//   err     out  start-rejected pulse, limit < base (registered)
//
// States
//   state  | meaning
//   S_IDLE | counter parked, waiting for a valid start
//   S_LOAD | one cycle, counter loads base
//   S_RUN  | counter increments; reload or finish at limit
// -----------------------------------------------------------------------------
module cnt_seq_ctrl
    import cnt_seq_pkg::*;
#(
    parameter int n = 4,
    parameter int m = 8
)
(
    input  logic         Clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic [n-1:0] base,
    input  logic [n-1:0] limit,
    input  logic [m-1:0] reps,
    input  logic [n-1:0] cnt_q,
    output logic         cnt_en,
    output logic         cnt_ld,
    output logic [n-1:0] cnt_d,
    output logic         busy,
    output logic         tick,
    output logic         done,
    output logic         err
);

    state_t       state_r;
    state_t       state_nxt;

    logic [n-1:0] base_r;
    logic [n-1:0] limit_r;
    logic [m-1:0] reps_r;
    logic [m-1:0] rep_cnt;

    logic         busy_r;
    logic         done_r;
    logic         err_r;

    logic         accept;
    logic         reject;
    logic         finish;
    logic         rep_dec;
    logic         at_limit;
    logic         run_forever;
    logic         more_reps;

    assign at_limit    = (cnt_q == limit_r);
    assign run_forever = (reps_r == '0);
    assign more_reps   = (rep_cnt > m'(1));

    always_comb begin
        state_nxt = state_r;
        cnt_en    = 1'b0;
        cnt_ld    = 1'b0;
        tick      = 1'b0;
        accept    = 1'b0;
        reject    = 1'b0;
        finish    = 1'b0;
        rep_dec   = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (start && !stop) begin
                    if (limit < base) begin
                        reject = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = S_LOAD;
                    end
                end
            end

            S_LOAD: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_en    = 1'b1;
                    cnt_ld    = 1'b1;
                    state_nxt = S_RUN;
                end
            end

            S_RUN: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_en = 1'b1;
                    if (at_limit) begin
                        tick = 1'b1;
                        if (run_forever || more_reps) begin
                            cnt_ld  = 1'b1;
                            rep_dec = !run_forever;
                        end else begin
                            // last interval: leave the counter parked at limit
                            cnt_en    = 1'b0;
                            finish    = 1'b1;
                            state_nxt = S_IDLE;
                        end
                    end
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            base_r  <= '0;
            limit_r <= '0;
            reps_r  <= '0;
            rep_cnt <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt;
            if (accept) begin
                base_r  <= base;
                limit_r <= limit;
                reps_r  <= reps;
                rep_cnt <= reps;
            end else if (rep_dec) begin
                rep_cnt <= rep_cnt - m'(1);
            end
            // registered view of "next state is not IDLE" so busy tracks state_r
            busy_r <= (state_nxt != S_IDLE);
            done_r <= finish;
            err_r  <= reject;
        end
    end

    assign cnt_d = base_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign err   = err_r;

endmodule

// File: doc/cnt_seq_ctrl.md
# cnt_seq_ctrl

Sequencing controller for the loadable up-counter stage: drives the counter's enable, load and load-data inputs and watches its count output, so the counter runs repeated intervals from a programmable base value to a programmable limit. Emits a one-cycle `tick` at the end of each interval and a one-cycle `done` after the programmed number of intervals. Sits directly upstream of the counter; the counter's `q` returns as `cnt_q`.

## Interface
- `n`, 4: counter width; must match the driven counter.
- `m`, 8: repetition-count width.
- `Clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a sequence; sampled only in IDLE.
- `stop`  in  1  abort; sampled in every state.
- `base`  in  n  interval start value; latched on accepted start.
- `limit`  in  n  interval end value; latched on accepted start.
- `reps`  in  m  interval count; 0 = run until `stop`. Latched on accepted start.
- `cnt_q`  in  n  counter output.
- `cnt_en`  out  1  counter enable.
- `cnt_ld`  out  1  counter load (meaningful only with `cnt_en`).
- `cnt_d`  out  n  counter load data; always equals latched base.
- `busy`  out  1  high in LOAD and RUN.
- `tick`  out  1  interval-end pulse.
- `done`  out  1  sequence-complete pulse, registered.
- `err`  out  1  start-rejected pulse, registered.

## Operation
- States: IDLE, LOAD, RUN.
- IDLE: `cnt_en`=0, `cnt_ld`=0. If `start`=1 and `stop`=0:
  - `limit`<`base` (unsigned): stay in IDLE; `err`=1 next cycle.
  - Otherwise: latch `base`/`limit`/`reps`; `rep_cnt`←`reps`; go to LOAD.
- LOAD (1 cycle): `cnt_en`=1, `cnt_ld`=1; go to RUN.
- RUN: `cnt_en`=1. When `cnt_q`==`limit_r`, `tick`=1 combinationally in the same cycle:
  - `reps_r`==0 or `rep_cnt`>1: `cnt_ld`=1 (reload base); decrement `rep_cnt` unless `reps_r`==0. Stay in RUN.
  - `rep_cnt`==1: `cnt_en`=0, so the counter holds at limit. Go to IDLE; `done`=1 next cycle.
- When `cnt_q`≠`limit_r` in RUN: `cnt_ld`=0, so the counter increments.
- `stop`=1 in LOAD or RUN: next state IDLE; `cnt_en`=0 that cycle; no `tick`, no `done`. `stop` has priority over `start` and over interval end.
- `start` while busy is ignored; latched values never change mid-sequence.
- `limit`==`base`: every RUN cycle is an interval end, so `tick` is high every RUN cycle.
- The counter never wraps, because reload happens at `limit_r` ≤ 2^n−1.
- `rep_cnt` is m bits and only decrements; it never underflows.

## Timing
- Reset: state IDLE. `cnt_en`, `cnt_ld`, `busy`, `tick`, `done`, `err` = 0. `cnt_d`, `base_r`, `limit_r`, `reps_r`, `rep_cnt` = 0.
- Reset mid-sequence: same values on the next edge. The counter is not reset by this block.
- With start sampled at cycle 0:
  - LOAD is cycle 1; first `cnt_q`=base at cycle 2.
  - Each interval lasts `limit`−`base`+1 cycles.
  - Tick k occurs at cycle 1+k·(`limit`−`base`+1).
  - `done` occurs one cycle after the last tick; `busy` falls in that same cycle.
- `tick` is combinational from state and `cnt_q`. `cnt_en`/`cnt_ld` are combinational from state, `cnt_q` and `stop`. All other outputs are registered.
- A new start is accepted in the same cycle `done` is high; minimum gap between sequences is 0 idle cycles.

## Structure
- Package `cnt_seq_pkg`: `state_t` enum {S_IDLE, S_LOAD, S_RUN}.
- No sub-module. State register, latched operands and `rep_cnt` are inline; the counter itself stays a separate instance at the integration level.
- Bench pairs this block with the counter stage (en/ld/D/q wired to `cnt_en`/`cnt_ld`/`cnt_d`/`cnt_q`).

## Test plan
- Normal run: `base`=2, `limit`=5, `reps`=2, start at cycle 0 → `tick` at cycles 5 and 9, `done` at 10, `busy` high cycles 1–9, `cnt_q` sequence 2,3,4,5,2,3,4,5.
- Degenerate interval: `base`=`limit`=7, `reps`=3 → `tick` high cycles 2,3,4; `done` at 5.
- Continuous with stop: `reps`=0, `base`=0, `limit`=3 → `tick` every 4 cycles. `stop` at cycle 12 → IDLE at 13, `cnt_en`=0 at 12, no `done`.
- Rejection and priority: `base`=9, `limit`=4 → `err` for one cycle, `busy` stays 0. Then `start`+`stop` together in IDLE → nothing starts.
- Busy start and back-to-back: `start` pulsed mid-RUN with new values → ignored, ticks unchanged. `start` in the `done` cycle → LOAD on the next cycle.
- Reset mid-RUN (`base`=1, `limit`=15, `reps`=4) → all outputs 0 on the next edge; the next start runs normally.
